// File: rtl/axil_rd_arbiter_if.sv
// axil_rd_arbiter_if: bundle of NUM parallel AXI-Lite read channels (AR + R)
interface axil_rd_arbiter_if #(
  parameter int NUM = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM-1:0][ADDR_WIDTH-1:0] araddr;
  logic [NUM-1:0]                 arvalid;
  logic [NUM-1:0]                 arready;
  logic [NUM-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM-1:0][1:0]            rresp;
  logic [NUM-1:0]                 rvalid;
  logic [NUM-1:0]                 rready;
  modport master(output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave(input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axil_rd_arbiter.sv
// axil_rd_arbiter: round-robin AXI-Lite read arbiter with in-order response routing
module axil_rd_arbiter #(
  parameter int NUM_SRCS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axil_rd_arbiter_if.slave               src_axi,
  axil_rd_arbiter_if.master              dst_axi,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           err_unexp_r
);
  localparam int IW = $clog2(NUM_SRCS);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [IW-1:0] rr_ptr, lock_idx, rr_sel, idx, sel, head;
  logic          lock_vld, full, empty, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] order_q [MAX_OUTST];
  always_comb begin
    rr_sel = rr_ptr;
    idx = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_SRCS);
      rr_sel = src_axi.arvalid[idx] ? idx : rr_sel;
    end
  end
  assign sel   = lock_vld ? lock_idx : rr_sel;
  assign full  = outst_cnt == CW'(MAX_OUTST);
  assign empty = outst_cnt == '0;
  assign head  = order_q[rd_ptr];
  assign dst_axi.arvalid[0] = src_axi.arvalid[sel] & ~full;
  assign dst_axi.araddr[0]  = src_axi.araddr[sel];
  assign src_axi.arready    = (dst_axi.arready[0] & ~full) ? NUM_SRCS'(1) << sel : '0;
  assign src_axi.rvalid     = (~empty & dst_axi.rvalid[0]) ? NUM_SRCS'(1) << head : '0;
  assign dst_axi.rready[0]  = ~empty & src_axi.rready[head];
  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_r
    assign src_axi.rdata[i] = dst_axi.rdata[0];
    assign src_axi.rresp[i] = (~empty && head == IW'(i)) ? dst_axi.rresp[0] : 2'b00;
  end
  assign push = dst_axi.arvalid[0] & dst_axi.arready[0];
  assign pop  = dst_axi.rvalid[0] & dst_axi.rready[0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      lock_vld    <= 1'b0;
      lock_idx    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outst_cnt   <= '0;
      err_unexp_r <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr   <= IW'((int'(sel) + 1) % NUM_SRCS);
        lock_vld <= 1'b0;
        wr_ptr   <= PW'((int'(wr_ptr) + 1) % MAX_OUTST);
      end else if (dst_axi.arvalid[0]) begin
        lock_vld <= 1'b1;
        lock_idx <= sel;
      end
      if (pop) rd_ptr <= PW'((int'(rd_ptr) + 1) % MAX_OUTST);
      outst_cnt <= outst_cnt + CW'(push) - CW'(pop);
      if (dst_axi.rvalid[0] & empty) err_unexp_r <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) order_q[wr_ptr] <= sel;
endmodule

// File: tb/tb_axil_rd_arbiter.sv
// tb_axil_rd_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_axil_rd_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);
  typedef struct { int s; logic [AW-1:0] a; } ent_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] outst_cnt;
  logic          err_unexp_r;
  int            n_vec = 0;
  int            n_err = 0;
  axil_rd_arbiter_if #(.NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) src_if ();
  axil_rd_arbiter_if #(.NUM(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dst_if ();
  axil_rd_arbiter #(.NUM_SRCS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n), .src_axi(src_if), .dst_axi(dst_if),
    .outst_cnt(outst_cnt), .err_unexp_r(err_unexp_r)
  );
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_if.araddr = '0; src_if.arvalid = '0; src_if.rready = '0;
    dst_if.arready = '0; dst_if.rdata = '0; dst_if.rresp = '0; dst_if.rvalid = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    #1;
    n_vec++; if (outst_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", outst_cnt); end
    n_vec++; if (err_unexp_r !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_unexp_r); end
    n_vec++; if (dst_if.arvalid !== 1'b0 || dst_if.rready !== 1'b0) begin n_err++; $display("FAIL reset_dst got=%b%b exp=00", dst_if.arvalid, dst_if.rready); end
    n_vec++; if (src_if.arready !== '0 || src_if.rvalid !== '0) begin n_err++; $display("FAIL reset_src got=%b/%b exp=00/00", src_if.arready, src_if.rvalid); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    src_if.araddr[0] = 32'h100; src_if.arvalid = 2'b01; dst_if.arready = 1'b1; src_if.rready = 2'b11;
    #1;
    n_vec++; if (dst_if.arvalid !== 1'b1 || dst_if.araddr[0] !== 32'h100) begin n_err++; $display("FAIL single_ar got=%b/%h exp=1/100", dst_if.arvalid, dst_if.araddr[0]); end
    n_vec++; if (src_if.arready !== 2'b01) begin n_err++; $display("FAIL single_arready got=%b exp=01", src_if.arready); end
    step();
    src_if.arvalid = '0;
    #1;
    n_vec++; if (outst_cnt !== CW'(1)) begin n_err++; $display("FAIL single_cnt1 got=%0d exp=1", outst_cnt); end
    step();
    step();
    dst_if.rvalid = 1'b1; dst_if.rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (src_if.rvalid !== 2'b01 || src_if.rdata[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_r got=%b/%h exp=01/deadbeef", src_if.rvalid, src_if.rdata[0]); end
    n_vec++; if (dst_if.rready !== 1'b1) begin n_err++; $display("FAIL single_rready got=%b exp=1", dst_if.rready); end
    step();
    dst_if.rvalid = 1'b0;
    #1;
    n_vec++; if (outst_cnt !== '0) begin n_err++; $display("FAIL single_cnt0 got=%0d exp=0", outst_cnt); end
  endtask

  task automatic test_rr();
    int q[$];
    do_reset();
    src_if.araddr[0] = 32'h10; src_if.araddr[1] = 32'h20; src_if.arvalid = 2'b11;
    dst_if.arready = 1'b1; src_if.rready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      dst_if.rvalid = q.size() > 0;
      dst_if.rdata = q.size() > 0 ? mdata(q[0] == 1 ? 32'h20 : 32'h10) : '0;
      #1;
      n_vec++; if (dst_if.araddr[0] !== ((c % 2) == 1 ? 32'h20 : 32'h10)) begin n_err++; $display("FAIL rr_addr c=%0d got=%h", c, dst_if.araddr[0]); end
      n_vec++; if (src_if.arready !== N'(1) << (c % 2)) begin n_err++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, src_if.arready, N'(1) << (c % 2)); end
      if (q.size() > 0) begin
        n_vec++; if (src_if.rvalid !== N'(1) << q[0] || src_if.rdata[q[0]] !== mdata(q[0] == 1 ? 32'h20 : 32'h10)) begin n_err++; $display("FAIL rr_resp c=%0d got=%b/%h exp src %0d", c, src_if.rvalid, src_if.rdata[q[0]], q[0]); end
        void'(q.pop_front());
      end
      step();
      q.push_back(c % 2);
    end
    idle();
    #1;
    n_vec++; if (outst_cnt !== CW'(1)) begin n_err++; $display("FAIL rr_cnt got=%0d exp=1", outst_cnt); end
  endtask

  task automatic test_lock();
    do_reset();
    src_if.araddr[0] = 32'h10; src_if.araddr[1] = 32'h20; src_if.arvalid = 2'b01; dst_if.arready = 1'b1;
    step();
    dst_if.arready = 1'b0;
    step();
    src_if.arvalid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (dst_if.arvalid !== 1'b1 || dst_if.araddr[0] !== 32'h10 || src_if.arready !== '0) begin n_err++; $display("FAIL lock_hold c=%0d got=%b/%h/%b exp=1/10/00", c, dst_if.arvalid, dst_if.araddr[0], src_if.arready); end
      step();
    end
    dst_if.arready = 1'b1;
    #1;
    n_vec++; if (src_if.arready !== 2'b01 || dst_if.araddr[0] !== 32'h10) begin n_err++; $display("FAIL lock_first got=%b/%h exp=01/10", src_if.arready, dst_if.araddr[0]); end
    step();
    src_if.arvalid = 2'b10;
    #1;
    n_vec++; if (src_if.arready !== 2'b10 || dst_if.araddr[0] !== 32'h20) begin n_err++; $display("FAIL lock_second got=%b/%h exp=10/20", src_if.arready, dst_if.araddr[0]); end
    step();
    src_if.arvalid = '0;
    #1;
    n_vec++; if (outst_cnt !== CW'(3)) begin n_err++; $display("FAIL lock_cnt got=%0d exp=3", outst_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    src_if.araddr[0] = 32'h40; src_if.arvalid = 2'b01; dst_if.arready = 1'b1; src_if.rready = 2'b11;
    for (int c = 0; c < MO; c++) begin
      #1;
      n_vec++; if (dst_if.arvalid !== 1'b1) begin n_err++; $display("FAIL full_fill c=%0d got=%b exp=1", c, dst_if.arvalid); end
      step();
    end
    #1;
    n_vec++; if (outst_cnt !== CW'(MO) || dst_if.arvalid !== 1'b0 || src_if.arready !== '0) begin n_err++; $display("FAIL full_stop got=%0d/%b/%b exp=%0d/0/00", outst_cnt, dst_if.arvalid, src_if.arready, MO); end
    dst_if.rvalid = 1'b1;
    #1;
    n_vec++; if (dst_if.rready !== 1'b1 || dst_if.arvalid !== 1'b0) begin n_err++; $display("FAIL full_pop got=%b/%b exp=1/0", dst_if.rready, dst_if.arvalid); end
    step();
    dst_if.rvalid = 1'b0;
    #1;
    n_vec++; if (outst_cnt !== CW'(MO - 1) || dst_if.arvalid !== 1'b1) begin n_err++; $display("FAIL full_resume got=%0d/%b exp=%0d/1", outst_cnt, dst_if.arvalid, MO - 1); end
    step();
    #1;
    n_vec++; if (outst_cnt !== CW'(MO)) begin n_err++; $display("FAIL full_refill got=%0d exp=%0d", outst_cnt, MO); end
    idle();
  endtask

  task automatic test_rready_bp();
    do_reset();
    src_if.araddr[0] = 32'h30; src_if.araddr[1] = 32'h50; src_if.arvalid = 2'b01; dst_if.arready = 1'b1;
    step();
    src_if.arvalid = 2'b10;
    step();
    src_if.arvalid = '0; dst_if.arready = 1'b0;
    dst_if.rvalid = 1'b1; dst_if.rdata = 32'h1111_0000; dst_if.rresp = 2'b00; src_if.rready = 2'b10;
    #1;
    n_vec++; if (dst_if.rready !== 1'b0 || src_if.rvalid !== 2'b01) begin n_err++; $display("FAIL bp_stall got=%b/%b exp=0/01", dst_if.rready, src_if.rvalid); end
    step();
    #1;
    n_vec++; if (outst_cnt !== CW'(2)) begin n_err++; $display("FAIL bp_nopop got=%0d exp=2", outst_cnt); end
    src_if.rready = 2'b11;
    #1;
    n_vec++; if (dst_if.rready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", dst_if.rready); end
    step();
    dst_if.rresp = 2'b10; dst_if.rdata = 32'h2222_0000; src_if.rready = 2'b01;
    #1;
    n_vec++; if (src_if.rvalid !== 2'b10 || src_if.rresp[1] !== 2'b10 || src_if.rresp[0] !== 2'b00) begin n_err++; $display("FAIL bp_route got=%b/%b/%b exp=10/10/00", src_if.rvalid, src_if.rresp[1], src_if.rresp[0]); end
    n_vec++; if (dst_if.rready !== 1'b0 || src_if.rdata[1] !== 32'h2222_0000) begin n_err++; $display("FAIL bp_head1 got=%b/%h exp=0/22220000", dst_if.rready, src_if.rdata[1]); end
    src_if.rready = 2'b10;
    #1;
    n_vec++; if (dst_if.rready !== 1'b1) begin n_err++; $display("FAIL bp_head1_rdy got=%b exp=1", dst_if.rready); end
    step();
    idle();
    #1;
    n_vec++; if (outst_cnt !== '0) begin n_err++; $display("FAIL bp_drain got=%0d exp=0", outst_cnt); end
  endtask

  task automatic test_err_reset();
    do_reset();
    dst_if.rvalid = 1'b1;
    #1;
    n_vec++; if (src_if.rvalid !== '0 || dst_if.rready !== 1'b0) begin n_err++; $display("FAIL err_empty got=%b/%b exp=00/0", src_if.rvalid, dst_if.rready); end
    step();
    dst_if.rvalid = 1'b0;
    #1;
    n_vec++; if (err_unexp_r !== 1'b1) begin n_err++; $display("FAIL err_set got=%b exp=1", err_unexp_r); end
    step();
    step();
    #1;
    n_vec++; if (err_unexp_r !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err_unexp_r); end
    src_if.araddr[0] = 32'h60; src_if.araddr[1] = 32'h70; src_if.arvalid = 2'b11; dst_if.arready = 1'b1;
    step();
    step();
    step();
    #1;
    n_vec++; if (outst_cnt !== CW'(3)) begin n_err++; $display("FAIL err_traffic got=%0d exp=3", outst_cnt); end
    rst_n = 1'b0;
    step();
    idle();
    #1;
    n_vec++; if (outst_cnt !== '0 || err_unexp_r !== 1'b0) begin n_err++; $display("FAIL midreset_state got=%0d/%b exp=0/0", outst_cnt, err_unexp_r); end
    n_vec++; if (dst_if.arvalid !== 1'b0 || dst_if.rready !== 1'b0 || src_if.arready !== '0 || src_if.rvalid !== '0) begin n_err++; $display("FAIL midreset_out got=%b%b/%b/%b exp=00/00/00", dst_if.arvalid, dst_if.rready, src_if.arready, src_if.rvalid); end
    rst_n = 1'b1;
    src_if.araddr[0] = 32'h60; src_if.araddr[1] = 32'h70; src_if.arvalid = 2'b11; dst_if.arready = 1'b1;
    #1;
    n_vec++; if (dst_if.araddr[0] !== 32'h60 || src_if.arready !== 2'b01) begin n_err++; $display("FAIL midreset_rr got=%h/%b exp=60/01", dst_if.araddr[0], src_if.arready); end
    idle();
  endtask

  task automatic test_random();
    ent_t          mq[$];
    ent_t          e;
    logic [AW-1:0] sq[$];
    logic [AW-1:0] slv_addr;
    logic [N-1:0]  req;
    logic          ea, ar_hs, r_hs;
    int            m_rr, m_lock, es, hd;
    do_reset();
    m_rr = 0; m_lock = -1; hd = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!src_if.arvalid[i] && $urandom_range(0, 2) == 0) begin
          src_if.arvalid[i] = 1'b1;
          src_if.araddr[i] = $urandom() & 32'hFFFF_FFFC;
        end
      dst_if.arready = $urandom_range(0, 3) != 0;
      src_if.rready = N'($urandom());
      if (!dst_if.rvalid[0] && sq.size() > 0 && $urandom_range(0, 1) == 1) begin
        dst_if.rvalid = 1'b1; dst_if.rdata = mdata(sq[0]); dst_if.rresp = sq[0][5:4];
      end
      #1;
      req = src_if.arvalid;
      es = m_rr;
      if (m_lock >= 0) es = m_lock;
      else for (int k = 0; k < N; k++) if (req[(m_rr + k) % N]) begin es = (m_rr + k) % N; break; end
      ea = req[es] && mq.size() < MO;
      n_vec++; if (dst_if.arvalid[0] !== ea) begin n_err++; $display("FAIL rnd_arvalid c=%0d got=%b exp=%b", c, dst_if.arvalid, ea); end
      if (ea) begin
        n_vec++; if (dst_if.araddr[0] !== src_if.araddr[es]) begin n_err++; $display("FAIL rnd_araddr c=%0d got=%h exp=%h", c, dst_if.araddr[0], src_if.araddr[es]); end
      end
      n_vec++; if (src_if.arready !== ((dst_if.arready[0] && mq.size() < MO) ? N'(1) << es : N'(0))) begin n_err++; $display("FAIL rnd_arready c=%0d got=%b src=%0d", c, src_if.arready, es); end
      n_vec++; if (outst_cnt !== CW'(mq.size())) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, outst_cnt, mq.size()); end
      if (mq.size() > 0) begin
        hd = mq[0].s;
        n_vec++; if (src_if.rvalid !== (dst_if.rvalid[0] ? N'(1) << hd : N'(0))) begin n_err++; $display("FAIL rnd_rvalid c=%0d got=%b head=%0d", c, src_if.rvalid, hd); end
        n_vec++; if (dst_if.rready[0] !== src_if.rready[hd]) begin n_err++; $display("FAIL rnd_rready c=%0d got=%b exp=%b", c, dst_if.rready, src_if.rready[hd]); end
        if (dst_if.rvalid[0]) begin
          n_vec++; if (src_if.rdata[hd] !== mdata(mq[0].a) || src_if.rresp[hd] !== mq[0].a[5:4] || src_if.rresp[1 - hd] !== 2'b00) begin n_err++; $display("FAIL rnd_rdata c=%0d got=%h/%b exp=%h/%b", c, src_if.rdata[hd], src_if.rresp[hd], mdata(mq[0].a), mq[0].a[5:4]); end
        end
      end else begin
        n_vec++; if (src_if.rvalid !== '0 || dst_if.rready[0] !== 1'b0) begin n_err++; $display("FAIL rnd_idle_r c=%0d got=%b/%b exp=00/0", c, src_if.rvalid, dst_if.rready); end
      end
      ar_hs = ea && dst_if.arready[0];
      r_hs = dst_if.rvalid[0] && mq.size() > 0 && src_if.rready[hd];
      e.s = es; e.a = src_if.araddr[es];
      slv_addr = dst_if.araddr[0];
      step();
      if (ar_hs) begin
        mq.push_back(e);
        sq.push_back(slv_addr);
        src_if.arvalid[es] = 1'b0;
        m_rr = (es + 1) % N;
        m_lock = -1;
      end else if (ea) m_lock = es;
      if (r_hs) begin
        void'(mq.pop_front());
        void'(sq.pop_front());
        dst_if.rvalid = 1'b0;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_full();
    test_rready_bp();
    test_err_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
